// File: rtl/stack_ctrl_seq_if.sv
// ----------------------------------------------------------------------------
// stack_ctrl_seq_if
// Instruction handshake and control-strobe bundle for stack_ctrl_seq.
//   master : instruction source / control consumer (fetch + datapath side)
//   slave  : the sequencer itself
// Signals:
//   i_instruction  [0:INSTR_W-1]  instruction word, bit 0 is MSB
//   i_instrValid / o_instrReady   acceptance handshake
//   i_faultClr                    clears the sticky fault
//   o_ctrlValid, o_phase          control-valid pulse and phase indicator
//   o_stkAddrSel, o_stkWCtrl, o_RWCtrl, o_TWCtrl, o_carryWCtrl  strobes
//   o_instrOP, o_jCtrl            ALU opcode and jump control
//   o_dsp, o_rsp                  data/return stack entry counts
//   o_fault, o_faultCode          sticky fault flag and cause
// ----------------------------------------------------------------------------
interface stack_ctrl_seq_if #(
    parameter int OP_W = 5,
    parameter int JC_W = 5,
    parameter int SP_W = 5
);
    localparam int INSTR_W = 8 + OP_W + JC_W;

    logic [0:INSTR_W-1] i_instruction;
    logic               i_instrValid;
    logic               o_instrReady;
    logic               i_faultClr;
    logic               o_ctrlValid;
    logic               o_phase;
    logic               o_stkAddrSel;
    logic               o_stkWCtrl;
    logic               o_RWCtrl;
    logic               o_TWCtrl;
    logic               o_carryWCtrl;
    logic [0:OP_W-1]    o_instrOP;
    logic [0:JC_W-1]    o_jCtrl;
    logic [SP_W-1:0]    o_dsp;
    logic [SP_W-1:0]    o_rsp;
    logic               o_fault;
    logic [1:0]         o_faultCode;

    modport master (
        output i_instruction, i_instrValid, i_faultClr,
        input  o_instrReady, o_ctrlValid, o_phase, o_stkAddrSel, o_stkWCtrl,
               o_RWCtrl, o_TWCtrl, o_carryWCtrl, o_instrOP, o_jCtrl,
               o_dsp, o_rsp, o_fault, o_faultCode
    );

    modport slave (
        input  i_instruction, i_instrValid, i_faultClr,
        output o_instrReady, o_ctrlValid, o_phase, o_stkAddrSel, o_stkWCtrl,
               o_RWCtrl, o_TWCtrl, o_carryWCtrl, o_instrOP, o_jCtrl,
               o_dsp, o_rsp, o_fault, o_faultCode
    );
endinterface

// File: rtl/stack_ctrl_seq.sv
// ----------------------------------------------------------------------------
// stack_ctrl_seq
// Registered stack-CPU control sequencer. Accepts instructions over a
// valid/ready handshake, decodes them into registered control strobes,
// tracks the data-stack and return-stack entry counts, runs stack-memory
// ALU ops as two phases and latches a sticky fault on over/underflow.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      stack_ctrl_seq_if.slave (handshake, strobes, pointers, fault)
// Build option:
//   STK_WRAP_EN  when defined, both stacks are ring buffers of DEPTH entries
//                and the fault path is never taken.
// ----------------------------------------------------------------------------
module stack_ctrl_seq #(
    parameter int OP_W  = 5,
    parameter int JC_W  = 5,
    parameter int DEPTH = 16,
    parameter int SP_W  = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    stack_ctrl_seq_if.slave bus
);
    localparam int INSTR_W = 8 + OP_W + JC_W;
    localparam int CTRL_W  = 5 + OP_W + JC_W;
    localparam logic [SP_W:0] DEPTH_V = (SP_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PH2   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic            sel;
        logic            stkw;
        logic            rw;
        logic            tw;
        logic            carry;
        logic [0:OP_W-1] op;
        logic [0:JC_W-1] jc;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'({CTRL_W{1'b0}});

    // Next pointer value; out-of-range results are caught by the fault check
    // unless the stacks are configured as ring buffers.
    function automatic logic [SP_W-1:0] ptr_next(input logic [SP_W-1:0] p,
                                                 input logic [SP_W:0]   inc,
                                                 input logic [SP_W:0]   dec);
        logic [SP_W:0] p_ext;
        p_ext = {1'b0, p};
`ifdef STK_WRAP_EN
        if (p_ext < dec) begin
            ptr_next = SP_W'(p_ext + DEPTH_V - dec);
        end else if ((p_ext + inc) >= DEPTH_V) begin
            ptr_next = SP_W'(p_ext + inc - DEPTH_V);
        end else begin
            ptr_next = SP_W'(p_ext + inc - dec);
        end
`else
        ptr_next = SP_W'(p_ext + inc - dec);
`endif
    endfunction

    // Depth violation: count would exceed DEPTH or drop below zero.
    function automatic logic ptr_bad(input logic [SP_W-1:0] p,
                                     input logic [SP_W:0]   inc,
                                     input logic [SP_W:0]   dec);
        ptr_bad = (({1'b0, p} + inc) > DEPTH_V) || ({1'b0, p} < dec);
    endfunction

    state_t          state_r;
    ctrl_t           ctrl_r, ctrl_s;
    logic            ctrl_valid_r, phase_r, pend_stkw_r;
    logic [SP_W-1:0] dsp_r, rsp_r, pend_dsp_r, pend_rsp_r;
    logic            fault_r;
    logic [1:0]      fault_code_r;

    logic [0:INSTR_W-1] instr_s;
    logic [1:0]      ds_code_s, rs_code_s, fault_code_s;
    logic [SP_W:0]   ds_inc_s, ds_dec_s, rs_inc_s, rs_dec_s;
    logic [SP_W-1:0] dsp_nx_s, rsp_nx_s;
    logic            is_alu_s, two_phase_s;

    assign instr_s = bus.i_instruction;

    // Instruction field decode, stack deltas, depth check and next pointers.
    always_comb begin
        is_alu_s = (instr_s[0:1] == 2'b11);
        if (is_alu_s) begin
            ds_code_s    = instr_s[4+OP_W:5+OP_W];
            rs_code_s    = instr_s[6+OP_W:7+OP_W];
            ctrl_s.sel   = instr_s[3+OP_W];
            ctrl_s.op    = instr_s[3:2+OP_W];
            ctrl_s.jc    = instr_s[8+OP_W:7+OP_W+JC_W];
            ctrl_s.carry = instr_s[2];
            ctrl_s.tw    = ~instr_s[2] & instr_s[2+OP_W];
            ctrl_s.stkw  = (instr_s[4+OP_W:5+OP_W] == 2'b01);
            ctrl_s.rw    = (instr_s[6+OP_W:7+OP_W] == 2'b01);
        end else begin
            // Literal: an implicit push into the top-of-stack register.
            ds_code_s    = 2'b01;
            rs_code_s    = 2'b00;
            ctrl_s       = CTRL_NONE;
            ctrl_s.tw    = 1'b1;
            ctrl_s.stkw  = 1'b1;
        end

        ds_inc_s = {(SP_W+1){1'b0}};
        ds_dec_s = {(SP_W+1){1'b0}};
        case (ds_code_s)
            2'b01:   ds_inc_s = (SP_W+1)'(2'd1);
            2'b10:   ds_dec_s = (SP_W+1)'(2'd1);
            2'b11:   ds_dec_s = (SP_W+1)'(2'd2);
            default: ds_inc_s = {(SP_W+1){1'b0}};
        endcase

        // rsDelta 11 is reserved and behaves as no change.
        rs_inc_s = {(SP_W+1){1'b0}};
        rs_dec_s = {(SP_W+1){1'b0}};
        case (rs_code_s)
            2'b01:   rs_inc_s = (SP_W+1)'(2'd1);
            2'b10:   rs_dec_s = (SP_W+1)'(2'd1);
            default: rs_inc_s = {(SP_W+1){1'b0}};
        endcase

        two_phase_s = is_alu_s & ctrl_s.sel & (ds_code_s != 2'b00);
        dsp_nx_s    = ptr_next(dsp_r, ds_inc_s, ds_dec_s);
        rsp_nx_s    = ptr_next(rsp_r, rs_inc_s, rs_dec_s);

`ifdef STK_WRAP_EN
        fault_code_s = 2'b00;
`else
        // Data-stack causes take priority over a return-stack cause.
        if (({1'b0, dsp_r} + ds_inc_s) > DEPTH_V) begin
            fault_code_s = 2'b01;
        end else if ({1'b0, dsp_r} < ds_dec_s) begin
            fault_code_s = 2'b10;
        end else if (ptr_bad(rsp_r, rs_inc_s, rs_dec_s)) begin
            fault_code_s = 2'b11;
        end else begin
            fault_code_s = 2'b00;
        end
`endif
    end

    // Sequencer FSM with registered strobes, pointers and fault state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= S_RUN;
            ctrl_r       <= CTRL_NONE;
            ctrl_valid_r <= 1'b0;
            phase_r      <= 1'b0;
            pend_stkw_r  <= 1'b0;
            dsp_r        <= {SP_W{1'b0}};
            rsp_r        <= {SP_W{1'b0}};
            pend_dsp_r   <= {SP_W{1'b0}};
            pend_rsp_r   <= {SP_W{1'b0}};
            fault_r      <= 1'b0;
            fault_code_r <= 2'b00;
        end else begin
            case (state_r)
                S_RUN: begin
                    phase_r <= 1'b0;
                    if (bus.i_instrValid && fault_code_s != 2'b00) begin
                        // Suppress the instruction; pointers hold.
                        ctrl_r       <= CTRL_NONE;
                        ctrl_valid_r <= 1'b0;
                        fault_r      <= 1'b1;
                        fault_code_r <= fault_code_s;
                        state_r      <= S_FAULT;
                    end else if (bus.i_instrValid) begin
                        ctrl_valid_r <= 1'b1;
                        ctrl_r       <= ctrl_s;
                        pend_stkw_r  <= ctrl_s.stkw;
                        if (two_phase_s) begin
                            // Stack RAM write and pointer move wait for phase 1.
                            ctrl_r.stkw <= 1'b0;
                            pend_dsp_r  <= dsp_nx_s;
                            pend_rsp_r  <= rsp_nx_s;
                            state_r     <= S_PH2;
                        end else begin
                            dsp_r   <= dsp_nx_s;
                            rsp_r   <= rsp_nx_s;
                            state_r <= S_RUN;
                        end
                    end else begin
                        ctrl_r       <= CTRL_NONE;
                        ctrl_valid_r <= 1'b0;
                    end
                end
                S_PH2: begin
                    // Other strobes are held from phase 0.
                    ctrl_valid_r <= 1'b1;
                    phase_r      <= 1'b1;
                    ctrl_r.stkw  <= pend_stkw_r;
                    dsp_r        <= pend_dsp_r;
                    rsp_r        <= pend_rsp_r;
                    state_r      <= S_RUN;
                end
                S_FAULT: begin
                    ctrl_r       <= CTRL_NONE;
                    ctrl_valid_r <= 1'b0;
                    phase_r      <= 1'b0;
                    if (bus.i_faultClr) begin
                        fault_r      <= 1'b0;
                        fault_code_r <= 2'b00;
                        state_r      <= S_RUN;
                    end else begin
                        state_r      <= S_FAULT;
                    end
                end
                default: begin
                    ctrl_r       <= CTRL_NONE;
                    ctrl_valid_r <= 1'b0;
                    phase_r      <= 1'b0;
                    state_r      <= S_RUN;
                end
            endcase
        end
    end

    // Ready is gated by reset so it is low for the whole reset interval.
    assign bus.o_instrReady = (state_r == S_RUN) && i_rst_n;
    assign bus.o_ctrlValid  = ctrl_valid_r;
    assign bus.o_phase      = phase_r;
    assign bus.o_stkAddrSel = ctrl_r.sel;
    assign bus.o_stkWCtrl   = ctrl_r.stkw;
    assign bus.o_RWCtrl     = ctrl_r.rw;
    assign bus.o_TWCtrl     = ctrl_r.tw;
    assign bus.o_carryWCtrl = ctrl_r.carry;
    assign bus.o_instrOP    = ctrl_r.op;
    assign bus.o_jCtrl      = ctrl_r.jc;
    assign bus.o_dsp        = dsp_r;
    assign bus.o_rsp        = rsp_r;
    assign bus.o_fault      = fault_r;
    assign bus.o_faultCode  = fault_code_r;
endmodule

// File: tb/tb_stack_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_stack_ctrl_seq
// Directed, table-driven bench for stack_ctrl_seq at default parameters
// (OP_W=5, JC_W=5, DEPTH=16, SP_W=5). Each vector drives one cycle of inputs,
// checks ready before the clock edge and all outputs after it. Multi-cycle
// corner cases (overflow fill, faults, reset mid-instruction, ring wrap when
// STK_WRAP_EN is defined) follow as hand-written sequences.
// ----------------------------------------------------------------------------
module tb_stack_ctrl_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    stack_ctrl_seq_if #(.OP_W(5), .JC_W(5), .SP_W(5)) bus ();

    stack_ctrl_seq #(.OP_W(5), .JC_W(5), .DEPTH(16), .SP_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [17:0] instr;
        logic        clr;
        logic        rdy;
        logic        cv, ph, sel, stkw, rw, tw, carry;
        logic [4:0]  op, jc, dsp, rsp;
        logic        fault;
        logic [1:0]  code;
    } vec_t;

    localparam logic [17:0] LIT  = 18'h00000;
    localparam logic [17:0] LITX = 18'h1ABCD;  // class 01: literal with junk fields

    function automatic logic [17:0] alu(input logic a, input logic [4:0] op,
                                        input logic sel, input logic [1:0] ds,
                                        input logic [1:0] rs, input logic [4:0] jc);
        alu = {2'b11, a, op, sel, ds, rs, jc};
    endfunction

    function automatic vec_t mkv(input logic valid, input logic [17:0] instr,
                                 input logic clr, input logic rdy,
                                 input logic cv, input logic ph, input logic sel,
                                 input logic stkw, input logic rw, input logic tw,
                                 input logic carry, input logic [4:0] op,
                                 input logic [4:0] jc, input logic [4:0] dsp,
                                 input logic [4:0] rsp, input logic fault,
                                 input logic [1:0] code);
        vec_t v;
        v.valid = valid; v.instr = instr; v.clr = clr; v.rdy = rdy;
        v.cv = cv; v.ph = ph; v.sel = sel; v.stkw = stkw; v.rw = rw;
        v.tw = tw; v.carry = carry; v.op = op; v.jc = jc;
        v.dsp = dsp; v.rsp = rsp; v.fault = fault; v.code = code;
        return v;
    endfunction

    function automatic vec_t lit_v(input logic rdy, input logic [4:0] dsp, input logic [4:0] rsp);
        return mkv(1'b1, LIT, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                   5'd0, 5'd0, dsp, rsp, 1'b0, 2'b00);
    endfunction

    function automatic vec_t idle_v(input logic rdy, input logic [4:0] dsp, input logic [4:0] rsp);
        return mkv(1'b0, LIT, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   5'd0, 5'd0, dsp, rsp, 1'b0, 2'b00);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input vec_t e);
        logic [31:0] got, exp;
        got = {2'b00, bus.o_ctrlValid, bus.o_phase, bus.o_stkAddrSel, bus.o_stkWCtrl,
               bus.o_RWCtrl, bus.o_TWCtrl, bus.o_carryWCtrl, bus.o_instrOP, bus.o_jCtrl,
               bus.o_dsp, bus.o_rsp, bus.o_fault, bus.o_faultCode};
        exp = {2'b00, e.cv, e.ph, e.sel, e.stkw, e.rw, e.tw, e.carry, e.op, e.jc,
               e.dsp, e.rsp, e.fault, e.code};
        check(name, got, exp);
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        bus.i_instrValid  = v.valid;
        bus.i_instruction = v.instr;
        bus.i_faultClr    = v.clr;
        #1;
        check({name, ".ready"}, {31'd0, bus.o_instrReady}, {31'd0, v.rdy});
        @(posedge clk);
        #1;
        check_outs(name, v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_instrValid = 1'b0;
        bus.i_faultClr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[16];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i_instruction = LIT;
        bus.i_instrValid  = 1'b0;
        bus.i_faultClr    = 1'b0;

        // cycle-by-cycle vectors; dsp/rsp are the counts after the edge
        tbl[0]  = idle_v(1'b1, 5'd0, 5'd0);
        tbl[1]  = lit_v(1'b1, 5'd1, 5'd0);
        tbl[2]  = mkv(1'b1, LITX, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                      5'd0, 5'd0, 5'd2, 5'd0, 1'b0, 2'b00);
        tbl[3]  = lit_v(1'b1, 5'd3, 5'd0);
        tbl[4]  = mkv(1'b1, alu(1'b1, 5'b00011, 1'b0, 2'b00, 2'b01, 5'b10101), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011, 5'b10101,
                      5'd3, 5'd1, 1'b0, 2'b00);
        tbl[5]  = mkv(1'b1, alu(1'b0, 5'b00001, 1'b1, 2'b10, 2'b00, 5'b00000), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 5'd0,
                      5'd3, 5'd1, 1'b0, 2'b00);
        tbl[6]  = mkv(1'b1, alu(1'b0, 5'b00001, 1'b1, 2'b10, 2'b00, 5'b00000), 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 5'd0,
                      5'd2, 5'd1, 1'b0, 2'b00);
        tbl[7]  = idle_v(1'b1, 5'd2, 5'd1);
        tbl[8]  = mkv(1'b1, alu(1'b0, 5'd0, 1'b1, 2'b01, 2'b10, 5'b00111), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'b00111,
                      5'd2, 5'd1, 1'b0, 2'b00);
        tbl[9]  = mkv(1'b0, alu(1'b0, 5'd0, 1'b1, 2'b01, 2'b10, 5'b00111), 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'b00111,
                      5'd3, 5'd0, 1'b0, 2'b00);
        tbl[10] = idle_v(1'b1, 5'd3, 5'd0);
        tbl[11] = lit_v(1'b1, 5'd4, 5'd0);
        tbl[12] = mkv(1'b1, alu(1'b0, 5'd0, 1'b0, 2'b00, 2'b11, 5'd0), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
                      5'd4, 5'd0, 1'b0, 2'b00);
        tbl[13] = mkv(1'b1, alu(1'b0, 5'b00101, 1'b0, 2'b11, 2'b00, 5'b00001), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00101, 5'b00001,
                      5'd2, 5'd0, 1'b0, 2'b00);
        tbl[14] = mkv(1'b1, alu(1'b1, 5'b11111, 1'b0, 2'b01, 2'b00, 5'b11000), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b11000,
                      5'd3, 5'd0, 1'b0, 2'b00);
        tbl[15] = idle_v(1'b1, 5'd3, 5'd0);

        // ready must be low while reset is asserted
        @(posedge clk);
        #1;
        check("in_reset.ready", {31'd0, bus.o_instrReady}, 32'd0);
        check_outs("in_reset", idle_v(1'b0, 5'd0, 5'd0));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

`ifndef STK_WRAP_EN
        // RS underflow, then valid alone is ignored, then clear together with valid
        apply(mkv(1'b1, alu(1'b0, 5'd0, 1'b0, 2'b00, 2'b10, 5'd0), 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
                  5'd3, 5'd0, 1'b1, 2'b11), "rs_unf");
        apply(mkv(1'b1, LIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd3, 5'd0, 1'b1, 2'b11), "rs_unf_hold");
        apply(mkv(1'b1, LIT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 2'b00), "rs_unf_clr");
        apply(idle_v(1'b1, 5'd3, 5'd0), "rs_unf_after");

        // fill to DEPTH, then the extra push overflows
        for (int i = 4; i <= 16; i++) begin
            apply(lit_v(1'b1, 5'(i), 5'd0), $sformatf("fill[%0d]", i));
        end
        apply(mkv(1'b1, LIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd16, 5'd0, 1'b1, 2'b01), "ds_ovf");
        apply(mkv(1'b0, LIT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd16, 5'd0, 1'b0, 2'b00), "ds_ovf_clr");
        apply(idle_v(1'b1, 5'd16, 5'd0), "ds_ovf_after");

        // DS overflow and RS underflow at once: DS code wins
        apply(mkv(1'b1, alu(1'b0, 5'd0, 1'b0, 2'b01, 2'b10, 5'd0), 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
                  5'd16, 5'd0, 1'b1, 2'b01), "both_flt");
        apply(mkv(1'b0, LIT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd16, 5'd0, 1'b0, 2'b00), "both_flt_clr");

        // pop2 at dsp=1 underflows
        do_reset();
        apply(lit_v(1'b1, 5'd1, 5'd0), "pop2_pre");
        apply(mkv(1'b1, alu(1'b0, 5'd0, 1'b0, 2'b11, 2'b00, 5'd0), 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
                  5'd1, 5'd0, 1'b1, 2'b10), "pop2_unf");
        apply(mkv(1'b1, LIT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 5'd1, 5'd0, 1'b0, 2'b00), "pop2_clr_valid");
        apply(idle_v(1'b1, 5'd1, 5'd0), "pop2_after");
`else
        // ring buffer: 17 pushes wrap to 1, two pops wrap back through 0 to 15
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            apply(lit_v(1'b1, 5'(i % 16), 5'd0), $sformatf("wrap[%0d]", i));
        end
        for (int i = 0; i < 2; i++) begin
            apply(mkv(1'b1, alu(1'b0, 5'd0, 1'b0, 2'b10, 2'b00, 5'd0), 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
                      (i == 0) ? 5'd0 : 5'd15, 5'd0, 1'b0, 2'b00), $sformatf("wrap_pop[%0d]", i));
        end
`endif

        // reset asserted in the phase-0 cycle of a two-phase op
        do_reset();
        apply(lit_v(1'b1, 5'd1, 5'd0), "rstmid_pre");
        apply(mkv(1'b1, alu(1'b0, 5'b00001, 1'b1, 2'b10, 2'b00, 5'd0), 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 5'd0,
                  5'd1, 5'd0, 1'b0, 2'b00), "rstmid_ph0");
        rst_n = 1'b0;
        bus.i_instrValid = 1'b0;
        #1;
        check("rstmid.ready", {31'd0, bus.o_instrReady}, 32'd0);
        check_outs("rstmid", idle_v(1'b0, 5'd0, 5'd0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(lit_v(1'b1, 5'd1, 5'd0), "rstmid_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
